sqm_fault_seq: RTL



---
 rtl/sqm_fault_seq_if.sv | 29 ++
 rtl/sqm_fault_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sqm_fault_seq_if.sv
// Start/done handshake and operand/result bundle for the sequential square-mod engine.
interface sqm_fault_seq_if #(
  parameter int W = 4
);
  localparam int LW = $clog2(2*W);
  localparam int ZW = $clog2(2*W+1);

  logic            start;
  logic [2*W-1:0]  A;
  logic [W-1:0]    B;
  logic            f_en;
  logic [LW-1:0]   f_loc;
  logic [1:0]      f_type;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  Y;
  logic [ZW-1:0]   Z;
  logic            div_zero;

  modport master (
    output start, A, B, f_en, f_loc, f_type,
    input  busy, done, Y, Z, div_zero
  );

  modport slave (
    input  start, A, B, f_en, f_loc, f_type,
    output busy, done, Y, Z, div_zero
  );
endinterface

// File: rtl/sqm_fault_seq.sv
// Sequential Y = fault(B*B) mod A engine: shift-add square, one-bit fault, restoring
// remainder, then serial popcount of the remainder into Z.
module sqm_fault_seq #(
  parameter int W  = 4,
  parameter int LW = $clog2(2*W),
  parameter int ZW = $clog2(2*W+1)
) (
  input  logic           clk,
  input  logic           rst_n,
  sqm_fault_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQ   = 3'd1,
    S_FLT  = 3'd2,
    S_MOD  = 3'd3,
    S_CNT  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   step_q, step_d;
  logic [2*W-1:0]  a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [2*W-1:0]  mc_q, mc_d;
  logic            fen_q, fen_d;
  logic [LW-1:0]   floc_q, floc_d;
  logic [1:0]      ftype_q, ftype_d;
  logic [2*W-1:0]  p_q, p_d;
  logic [2*W:0]    r_q, r_d;
  logic [ZW-1:0]   pc_q, pc_d;
  logic [2*W-1:0]  y_q, y_d;
  logic [ZW-1:0]   z_q, z_d;
  logic            dz_q, dz_d;
  logic            busy_q, busy_d;

  logic [2*W:0]    r_sh;
  logic [2*W-1:0]  fmask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mc_q    <= '0;
      fen_q   <= 1'b0;
      floc_q  <= '0;
      ftype_q <= '0;
      p_q     <= '0;
      r_q     <= '0;
      pc_q    <= '0;
      y_q     <= '0;
      z_q     <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mc_q    <= mc_d;
      fen_q   <= fen_d;
      floc_q  <= floc_d;
      ftype_q <= ftype_d;
      p_q     <= p_d;
      r_q     <= r_d;
      pc_q    <= pc_d;
      y_q     <= y_d;
      z_q     <= z_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    mc_d    = mc_q;
    fen_d   = fen_q;
    floc_d  = floc_q;
    ftype_d = ftype_q;
    p_d     = p_q;
    r_d     = r_q;
    pc_d    = pc_q;
    y_d     = y_q;
    z_d     = z_q;
    dz_d    = dz_q;
    r_sh    = {r_q[2*W-1:0], p_q[2*W-1]};
    fmask   = (2*W)'(1) << floc_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          mc_d    = {{W{1'b0}}, bus.B};
          fen_d   = bus.f_en;
          floc_d  = bus.f_loc;
          ftype_d = bus.f_type;
          p_d     = '0;
          r_d     = '0;
          pc_d    = '0;
          step_d  = '0;
          state_d = S_SQ;
        end
      end
      S_SQ: begin
        // Multiplier shifts right, multiplicand left: one partial product per cycle.
        p_d  = p_q + (b_q[0] ? mc_q : '0);
        b_d  = b_q >> 1;
        mc_d = mc_q << 1;
        if (step_q == LW'(W-1)) begin
          step_d  = '0;
          state_d = S_FLT;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_FLT: begin
        if (fen_q && ({1'b0, floc_q} < (LW+1)'(2*W))) begin
          case (ftype_q)
            2'b01:   p_d = p_q & ~fmask;
            2'b10:   p_d = p_q | fmask;
            2'b11:   p_d = p_q ^ fmask;
            default: p_d = p_q;
          endcase
        end
        state_d = S_MOD;
      end
      S_MOD: begin
        // P is consumed MSB first by shifting it left; A = 0 leaves R = P.
        p_d = p_q << 1;
        r_d = (r_sh >= {1'b0, a_q}) ? (r_sh - {1'b0, a_q}) : r_sh;
        if (step_q == LW'(2*W-1)) begin
          step_d  = '0;
          state_d = S_CNT;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_CNT: begin
        // Rotating the low 2W bits returns R to its original value after 2W steps.
        pc_d = pc_q + ZW'(r_q[0]);
        r_d  = {1'b0, r_q[0], r_q[2*W-1:1]};
        if (step_q == LW'(2*W-1)) begin
          step_d  = '0;
          y_d     = r_d[2*W-1:0];
          z_d     = pc_d;
          dz_d    = (a_q == '0);
          state_d = S_DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_q != S_IDLE) && (state_q != S_DONE) && (state_d != S_DONE);
  end

  assign bus.busy     = busy_q;
  assign bus.done     = (state_q == S_DONE);
  assign bus.Y        = y_q;
  assign bus.Z        = z_q;
  assign bus.div_zero = dz_q;

endmodule
